// File: rtl/fb_port_arbiter_if.sv
// Bus bundle between the framebuffer arbiter, its two clients and the RAM.
// The arbiter takes the slave view; the surrounding logic drives the master view.
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              ovf;
  logic              ovf_clr;
  logic [LVL_W-1:0]  fifo_level;

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata, ovf_clr,
    output rd_valid, rd_data, wr_ready, mem_addr, mem_we, mem_wdata, ovf, fifo_level
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata, ovf_clr,
    input  rd_valid, rd_data, wr_ready, mem_addr, mem_we, mem_wdata, ovf, fifo_level
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: display reads have strict priority, capture
// writes are queued in a small FIFO and drained only in cycles with no read.
module fb_port_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input logic             vgaclk,
  input logic             reset,
  fb_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {OP_IDLE, OP_RD, OP_WR} op_e;

  op_e               state_q, state_d;
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              full, empty, push, drop, pop;
  logic              vld_p0, vld_p1, rd_valid_p2;
  logic [ADDR_W-1:0] mem_addr_p0;
  logic [DATA_W-1:0] mem_wdata_p0, rd_data_p2;
  logic              ovf_q;

  // Occupancy comes from the registered level, so a slot freed by this
  // cycle's pop cannot be refilled in the same cycle.
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign push  = bus.wr_valid && !full;
  assign drop  = bus.wr_valid && full;
  assign pop   = (state_d == OP_WR);

  always_comb begin
    state_d = OP_IDLE;
    if (bus.rd_req)  state_d = OP_RD;
    else if (!empty) state_d = OP_WR;
  end

  always_ff @(posedge vgaclk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.wr_addr;
      fifo_data[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state_q      <= OP_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      ovf_q        <= 1'b0;
      mem_addr_p0  <= '0;
      mem_wdata_p0 <= '0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      rd_valid_p2  <= 1'b0;
      rd_data_p2   <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);

      // A drop wins over a simultaneous clear so no overflow goes unreported.
      if (drop)             ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;

      // p0: RAM command register
      case (state_d)
        OP_RD: mem_addr_p0 <= bus.rd_addr;
        OP_WR: begin
          mem_addr_p0  <= fifo_addr[rd_ptr];
          mem_wdata_p0 <= fifo_data[rd_ptr];
        end
        default: ;
      endcase
      vld_p0 <= bus.rd_req;

      // p1: RAM access in flight
      vld_p1 <= vld_p0;

      // p2: capture RAM output
      rd_valid_p2 <= vld_p1;
      if (vld_p1) rd_data_p2 <= bus.mem_rdata;
    end
  end

  assign bus.wr_ready   = !full && !reset;
  assign bus.mem_addr   = mem_addr_p0;
  assign bus.mem_we     = (state_q == OP_WR);
  assign bus.mem_wdata  = mem_wdata_p0;
  assign bus.rd_valid   = rd_valid_p2;
  assign bus.rd_data    = rd_data_p2;
  assign bus.ovf        = ovf_q;
  assign bus.fifo_level = level;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: a cycle table for the write, priority
// and overflow paths, plus hand sequences for pipelined reads and reset.
module tb_fb_port_arbiter;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic vgaclk = 1'b0;
  logic reset  = 1'b1;
  always #5 vgaclk = ~vgaclk;

  fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .vgaclk (vgaclk),
    .reset  (reset),
    .bus    (bus)
  );

  // Synchronous single-port RAM model with a backdoor write for preloading.
  logic [7:0]  ram [0:(1<<18)-1];
  logic        bd_we = 1'b0;
  logic [17:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  always @(posedge vgaclk) begin
    if (bd_we)           ram[bd_addr] <= bd_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct {
    logic        rd_req;
    logic [17:0] rd_addr;
    logic        wr_valid;
    logic [17:0] wr_addr;
    logic [7:0]  wr_data;
    logic        ovf_clr;
    logic        e_we;
    logic [17:0] e_addr;
    logic [7:0]  e_wdata;
    logic [3:0]  e_lvl;
    logic        e_rdy;
    logic        e_rvld;
    logic [7:0]  e_rdata;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(int rq, int ra, int wv, int wa, int wd, int oc,
                              int we, int ma, int wdt, int lv, int rdy,
                              int rv, int rdat, int ov);
    vec_t v;
    v.rd_req = rq[0];   v.rd_addr = ra[17:0];
    v.wr_valid = wv[0]; v.wr_addr = wa[17:0]; v.wr_data = wd[7:0];
    v.ovf_clr = oc[0];
    v.e_we = we[0];     v.e_addr = ma[17:0];  v.e_wdata = wdt[7:0];
    v.e_lvl = lv[3:0];  v.e_rdy = rdy[0];
    v.e_rvld = rv[0];   v.e_rdata = rdat[7:0]; v.e_ovf = ov[0];
    return v;
  endfunction

  task automatic tick();
    @(posedge vgaclk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic rq, logic [17:0] ra, logic wv, logic [17:0] wa,
                       logic [7:0] wd, logic oc);
    bus.rd_req = rq; bus.rd_addr = ra;
    bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
    bus.ovf_clr = oc;
  endtask

  task automatic chk_all_zero(string tag);
    n_vec++;
    chk({tag, " mem_we"},     32'(bus.mem_we),     32'd0);
    chk({tag, " mem_addr"},   32'(bus.mem_addr),   32'd0);
    chk({tag, " mem_wdata"},  32'(bus.mem_wdata),  32'd0);
    chk({tag, " rd_valid"},   32'(bus.rd_valid),   32'd0);
    chk({tag, " rd_data"},    32'(bus.rd_data),    32'd0);
    chk({tag, " ovf"},        32'(bus.ovf),        32'd0);
    chk({tag, " fifo_level"}, 32'(bus.fifo_level), 32'd0);
    chk({tag, " wr_ready"},   32'(bus.wr_ready),   32'd0);
  endtask

  initial begin
    int nvalid;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);

    // Preload RAM through the backdoor while the arbiter is held in reset.
    for (int i = 0; i < 16; i++) begin
      bd_we = 1'b1; bd_addr = 18'(i); bd_data = 8'(i);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      bd_we = 1'b1; bd_addr = 18'('h200 + i); bd_data = 8'h00;
      tick();
    end
    bd_we = 1'b0;
    chk_all_zero("reset_hold");
    reset = 1'b0;
    tick();
    n_vec++;
    chk("post_reset wr_ready",   32'(bus.wr_ready),   32'd1);
    chk("post_reset fifo_level", 32'(bus.fifo_level), 32'd0);

    // Write then read back.
    tbl.push_back(mk(0,0,1,'h123,'hA5,0, 0,0,0,       1,1, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        1,'h123,'hA5, 0,1, 0,0,0));
    tbl.push_back(mk(1,'h123,0,0,0,0,    0,'h123,'hA5, 0,1, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,'h123,'hA5, 0,1, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,'h123,'hA5, 0,1, 1,'hA5,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,'h123,'hA5, 0,1, 0,'hA5,0));
    // Reads held for 10 cycles while 3 writes queue up, then drain in order.
    tbl.push_back(mk(1,5,1,'h300,'h11,0, 0,5,'hA5, 1,1, 0,'hA5,0));
    tbl.push_back(mk(1,5,1,'h301,'h22,0, 0,5,'hA5, 2,1, 0,'hA5,0));
    tbl.push_back(mk(1,5,1,'h302,'h33,0, 0,5,'hA5, 3,1, 1,5,0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(1,5,0,0,0,0,      0,5,'hA5, 3,1, 1,5,0));
    tbl.push_back(mk(0,0,0,0,0,0,        1,'h300,'h11, 2,1, 1,5,0));
    tbl.push_back(mk(0,0,0,0,0,0,        1,'h301,'h22, 1,1, 1,5,0));
    tbl.push_back(mk(0,0,0,0,0,0,        1,'h302,'h33, 0,1, 0,5,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,'h302,'h33, 0,1, 0,5,0));
    // Fill to full under reads, drop the 9th, clear vs. drop priority.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1,6,1,'h400+i,'h50+i,0, 0,6,'h33, i+1, (i<7)?1:0,
                       (i>=2)?1:0, (i>=2)?6:5, 0));
    tbl.push_back(mk(1,6,1,'h408,'h58,0, 0,6,'h33, 8,0, 1,6,1));
    tbl.push_back(mk(1,6,1,'h409,'h59,1, 0,6,'h33, 8,0, 1,6,1));
    tbl.push_back(mk(1,6,0,0,0,1,        0,6,'h33, 8,0, 1,6,0));
    // Push while full is rejected even though a pop happens the same cycle.
    tbl.push_back(mk(0,0,1,'h4FF,'hEE,0, 1,'h400,'h50, 7,1, 1,6,1));
    tbl.push_back(mk(0,0,0,0,0,1,        1,'h401,'h51, 6,1, 1,6,0));
    for (int j = 2; j < 8; j++)
      tbl.push_back(mk(0,0,0,0,0,0,      1,'h400+j,'h50+j, 7-j,1, 0,6,0));
    tbl.push_back(mk(0,0,0,0,0,0,        0,'h407,'h57, 0,1, 0,6,0));

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("v%0d", i);
      drive(tbl[i].rd_req, tbl[i].rd_addr, tbl[i].wr_valid, tbl[i].wr_addr,
            tbl[i].wr_data, tbl[i].ovf_clr);
      tick();
      n_vec++;
      chk({t, " mem_we"},     32'(bus.mem_we),     32'(tbl[i].e_we));
      chk({t, " mem_addr"},   32'(bus.mem_addr),   32'(tbl[i].e_addr));
      chk({t, " mem_wdata"},  32'(bus.mem_wdata),  32'(tbl[i].e_wdata));
      chk({t, " fifo_level"}, 32'(bus.fifo_level), 32'(tbl[i].e_lvl));
      chk({t, " wr_ready"},   32'(bus.wr_ready),   32'(tbl[i].e_rdy));
      chk({t, " rd_valid"},   32'(bus.rd_valid),   32'(tbl[i].e_rvld));
      chk({t, " rd_data"},    32'(bus.rd_data),    32'(tbl[i].e_rdata));
      chk({t, " ovf"},        32'(bus.ovf),        32'(tbl[i].e_ovf));
    end
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);

    // Pipelined reads of addresses 0..15 (RAM holds data = addr).
    nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      bus.rd_req = (c < 16); bus.rd_addr = 18'(c);
      tick();
      n_vec++;
      chk($sformatf("pipe%0d rd_valid", c), 32'(bus.rd_valid),
          32'((c >= 2 && c < 18) ? 1 : 0));
      if (bus.rd_valid) nvalid++;
      if (c >= 2 && c < 18)
        chk($sformatf("pipe%0d rd_data", c), 32'(bus.rd_data), 32'(c - 2));
    end
    n_vec++;
    chk("pipe valid_count", 32'(nvalid), 32'd16);
    bus.rd_req = 1'b0;

    // Queue 5 writes under reads, let two pops issue, then reset mid-drain.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, '0, 1'b1, 18'('h200 + i), 8'('hC0 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    tick();
    n_vec++;
    chk("drain0 mem_we",   32'(bus.mem_we),   32'd1);
    chk("drain0 mem_addr", 32'(bus.mem_addr), 32'h200);
    tick();
    n_vec++;
    chk("drain1 mem_we",     32'(bus.mem_we),     32'd1);
    chk("drain1 mem_addr",   32'(bus.mem_addr),   32'h201);
    chk("drain1 fifo_level", 32'(bus.fifo_level), 32'd3);
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_vec++;
      chk($sformatf("after_reset%0d mem_we", c), 32'(bus.mem_we), 32'd0);
    end
    n_vec++;
    chk("after_reset fifo_level", 32'(bus.fifo_level), 32'd0);
    chk("after_reset wr_ready",   32'(bus.wr_ready),   32'd1);
    chk("after_reset rd_valid",   32'(bus.rd_valid),   32'd0);
    n_vec++;
    chk("ram 0x200", 32'(ram[18'h200]), 32'hC0);
    for (int i = 1; i < 5; i++)
      chk($sformatf("ram 0x%0h", 'h200 + i), 32'(ram[18'('h200 + i)]), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one synchronous single-port framebuffer RAM between two clients on the pixel clock domain.
- Client 1 is the display prefetch path: real-time reads. It has strict priority.
- Client 2 is the capture path: pixel-byte writes, buffered in an internal FIFO.
- Sits between the VGA output pipeline, the capture logic and the RAM. Writes drain only in cycles with no read request, so they complete during display blanking and idle gaps.

Parameters:
- ADDR_W, 18, framebuffer address width.
- DATA_W, 8, RAM word width.
- DEPTH, 8, write FIFO depth in entries. Must be a power of 2, ≥2.

Ports:
- vgaclk  in  1  pixel clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_req  in  1  display read request, one per cycle, no backpressure.
- rd_addr  in  ADDR_W  read address, sampled with rd_req.
- rd_valid  out  1  read data valid strobe.
- rd_data  out  DATA_W  read data.
- wr_valid  in  1  capture write offered.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  FIFO not full.
- mem_addr  out  ADDR_W  RAM address, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_wdata  out  DATA_W  RAM write data, registered.
- mem_rdata  in  DATA_W  RAM read data. Valid one cycle after the matching mem_addr.
- ovf  out  1  sticky write-overflow flag.
- ovf_clr  in  1  clears ovf.
- fifo_level  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO flushed (level 0); op state IDLE. Because level is 0, wr_ready is 1 from the first cycle after reset release.
- FIFO push and overflow:
  - wr_ready = (fifo_level != DEPTH), from the registered level.
  - A push occurs when wr_valid && wr_ready.
  - wr_valid while full drops the entry and sets ovf.
- Op state register, one of IDLE/RD/WR, chosen each cycle:
  - if rd_req → RD: mem_addr<=rd_addr, mem_we<=0.
  - else if FIFO not empty → WR: pop head, mem_addr<=head addr, mem_wdata<=head data, mem_we<=1.
  - else → IDLE: mem_we<=0; mem_addr holds its value.
- Read latency is fixed: rd_req high at edge k → rd_valid=1 and rd_data=mem_rdata registered at edge k+2.
  - Back-to-back reads pipeline at one per cycle.
  - rd_valid is 0 otherwise, and rd_data holds its last value.
- Priority: reads always win and there is no starvation guard. While rd_req is held continuously, mem_we stays 0 and the FIFO only fills.
- No bypass:
  - An entry pushed at edge k is poppable at edge k+1 at the earliest.
  - Push and pop in the same cycle leave the level unchanged.
  - Push to a full FIFO is rejected even if a pop occurs in that same cycle.
- Coherence: reads return RAM contents only. There is no forwarding from pending FIFO entries; a read of an address with a queued write returns the old value.
- ovf priority: a drop in the same cycle as ovf_clr leaves ovf=1. Otherwise ovf_clr clears it at the next edge.
- FIFO pointers are DEPTH-modulo and wrap silently; level never exceeds DEPTH.
- Reset mid-operation:
  - Queued writes are discarded.
  - An in-flight read produces no rd_valid.
  - A mem_we in progress drops to 0 asynchronously.

Test Plan:
- Reset check: assert reset mid-run → every output 0 immediately. After release: wr_ready=1, fifo_level=0.
- Write then read-back:
  - Push addr 0x00123 data 0xA5 with rd_req=0 → one cycle later mem_we=1, mem_addr=0x00123, mem_wdata=0xA5.
  - Then rd_req with addr 0x00123 → rd_valid=1, rd_data=0xA5 exactly 2 cycles later.
- Read priority:
  - Queue 3 writes while rd_req is held for 10 cycles → mem_we=0 throughout and fifo_level=3.
  - Drop rd_req → exactly 3 consecutive mem_we pulses in FIFO order, then level 0.
- Overflow:
  - Hold rd_req and push 9 entries → wr_ready falls after the 8th, the 9th is dropped, ovf=1.
  - Pulse ovf_clr together with a 10th push while still full → ovf stays 1.
  - Pulse ovf_clr alone → ovf=0.
- Pipelined reads: rd_req for 16 cycles at addrs 0..15 against a preloaded RAM (data=addr) → rd_valid high 16 cycles, starting 2 cycles after the first request, with data 0..15 in order.
- Reset mid-drain: with 5 writes queued and draining, assert reset → mem_we drops immediately. After release, no further writes issue; the RAM shows only the writes completed before reset.
